key_light_fader: RTL and testbench
==================================

Name: key_light_fader

Overview:
- Parametrised successor to the keyboard note-light block: maps ASCII key codes to one of N_CH note channels and drives each LED channel with PWM brightness.
- A keypress lights its channel at full brightness, holds for a programmable time, then fades linearly to off. Channels run independently.
- Sits between the keyboard decoder (ASCII code plus valid strobe) and the board RGB LED pins, alongside the synthesis/sound path.

Parameters:
- N_CH, 12, number of note channels/LED bits; 1..12. Key-map entries with index >= N_CH are ignored.
- PWM_BITS, 8, PWM resolution and brightness-level width.
- TICK_DIV, 100000, clk cycles per timing tick; >= 2.
- HOLD_TICKS, 50, ticks at full brightness after a trigger; >= 0.
- FADE_STEP, 4, level decrement per tick during fade; 1..2^PWM_BITS-1.

Ports:
- clk  in  1  master clock.
- rst  in  1  reset, asynchronous, active-high.
- inSel  in  8  ASCII key code.
- inValid  in  1  single-cycle strobe qualifying inSel.
- outLED  out  N_CH  PWM drive, one bit per channel; registered.
- outActive  out  N_CH  per-channel level != 0; registered.

Behaviour:
- Reset (asynchronous, active-high): all levels, hold counters, prescaler and PWM counter go to 0; outLED and outActive go to 0 immediately. Asserting rst mid-hold or mid-fade aborts everything.
- Key map, index 0..11: z s x d c v g b h n j m (0x7A 0x73 0x78 0x64 0x63 0x76 0x67 0x62 0x68 0x6E 0x6A 0x6D).
- Codes not in the map, or mapped to an index >= N_CH, are ignored with no state change. inSel is don't-care when inValid = 0.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick is asserted for the single cycle when the count equals TICK_DIV-1.
- Trigger: inValid = 1 with a mapped code at edge k. On that edge, level[i] <= MAX (2^PWM_BITS-1) and hold[i] <= HOLD_TICKS. outActive[i] rises at k+1.
  - Retriggering an active channel restarts its hold from full brightness.
- Per tick, for each channel not triggered in the same cycle:
  - if hold > 0: hold decrements;
  - else if level > 0: level <= level - FADE_STEP, saturating at 0 (no wrap-around).
- Simultaneous trigger and tick on the same channel: the trigger wins and that tick is not applied to that channel.
- Only one channel can trigger per cycle. Other channels continue decaying in parallel.
- PWM: a free-running PWM_BITS counter advances every clk.
  - outLED[i] <= (level[i] == MAX) or (pwm_cnt < level[i]).
  - level 0 gives constant off; MAX gives constant on.
  - outLED lags level by one cycle.
- outActive[i] <= (level[i] != 0).
- With HOLD_TICKS = 0, fading starts at the first tick after the trigger.
- Fade length from MAX to 0 is ceil(MAX / FADE_STEP) ticks.

Decomposition:
- Shared package key_light_pkg holds:
  - KEY_CODES, a 12-entry array of 8-bit ASCII codes in channel order;
  - N_KEYS = 12;
  - a function key_to_idx returning {hit, 4-bit idx}.
  - The synthesis/sound path reuses the same package so notes and lights stay consistent.
- One sub-module, light_channel: holds the level and hold registers, the trigger/tick update and the PWM compare. It is instantiated N_CH times from a generate loop.
- The top level owns the prescaler, the PWM counter and the key decode.

Test Plan (TICK_DIV=4, HOLD_TICKS=2, FADE_STEP=64, PWM_BITS=8, N_CH=12):
- Reset release, then inValid with 0x7A (z) -> level[0]=255, outActive=0x001 next cycle; outLED[0] constantly 1 through hold.
- Continue after the z trigger -> 2 ticks (8 cycles) of hold, then levels 191, 127, 63, 0 on successive ticks. outLED[0] duty is 191/256 at level 191. outActive[0] clears after the 4th fade tick.
- Trigger 0x6D (m) while channel 0 is fading at level 127 -> channel 11 goes to 255 and channel 0 keeps decaying. Retriggering z at level 63 -> channel 0 returns to 255 with hold restarted.
- inValid with 0x41 ('A'), and with 0x6D when N_CH=8 -> no outActive change. inSel toggling with inValid=0 -> no change.
- Trigger aligned to the same edge as a tick -> level 255 and hold 2, not decremented.
- Assert rst asynchronously (mid-cycle) during a fade -> outLED and outActive are 0 before the next clk edge. After release there is no residual light.

Source files
------------

// File: rtl/key_light_pkg.sv
// Shared key map for the note lights and the synthesis path, so both sides
// always agree on which ASCII key drives which note channel.
package key_light_pkg;

  localparam int N_KEYS = 12;

  // Channel order: z s x d c v g b h n j m
  localparam logic [7:0] KEY_CODES [N_KEYS] = '{
    8'h7A, 8'h73, 8'h78, 8'h64, 8'h63, 8'h76,
    8'h67, 8'h62, 8'h68, 8'h6E, 8'h6A, 8'h6D
  };

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } key_hit_t;

  function automatic key_hit_t key_to_idx(input logic [7:0] code);
    key_hit_t r;
    r = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (code == KEY_CODES[i]) begin
        r.hit = 1'b1;
        r.idx = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_light_fader_channel.sv
// One note light: full brightness on trigger, hold for HOLD_TICKS ticks,
// then a linear fade to off, rendered as PWM against the shared counter.
module light_channel #(
  parameter int PWM_BITS   = 8,
  parameter int HOLD_TICKS = 50,
  parameter int FADE_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trig,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                active
);

  localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [PWM_BITS-1:0] MAX  = '1;
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(FADE_STEP);

  logic [PWM_BITS-1:0] level_q, level_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                led_q, led_d;
  logic                active_q, active_d;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    level_d  = level_q;
    hold_d   = hold_q;
    if (trig) begin
      // A trigger on a tick edge swallows that tick for this channel.
      level_d = MAX;
      hold_d  = HOLD_W'(HOLD_TICKS);
    end else if (tick) begin
      if (hold_q != '0)          hold_d  = hold_q - 1'b1;
      else if (level_q >= STEP)  level_d = level_q - STEP;
      else                       level_d = '0;
    end
    led_d    = (level_q == MAX) || (pwm_cnt < level_q);
    active_d = (level_q != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q  <= '0;
      hold_q   <= '0;
      led_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      level_q  <= level_d;
      hold_q   <= hold_d;
      led_q    <= led_d;
      active_q <= active_d;
    end
  end

  assign led    = led_q;
  assign active = active_q;

endmodule

// File: rtl/key_light_fader.sv
// Keyboard note lights: decodes ASCII keys onto N_CH channels and owns the
// shared timing prescaler and PWM counter that every channel runs from.
module key_light_fader
  import key_light_pkg::*;
#(
  parameter int N_CH       = 12,
  parameter int PWM_BITS   = 8,
  parameter int TICK_DIV   = 100000,
  parameter int HOLD_TICKS = 50,
  parameter int FADE_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      inSel,
  input  logic            inValid,
  output logic [N_CH-1:0] outLED,
  output logic [N_CH-1:0] outActive
);

  localparam int PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                tick;
  key_hit_t            key_hit;
  logic [N_CH-1:0]     trig;

  always_comb begin
    tick    = (presc_q == PRE_W'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
    pwm_d   = pwm_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      pwm_q   <= '0;
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
    end
  end

  assign key_hit = key_to_idx(inSel);

  // Indices beyond N_CH simply match no channel, so those keys are ignored.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign trig[i] = inValid && key_hit.hit && (key_hit.idx == 4'(i));

    light_channel #(
      .PWM_BITS  (PWM_BITS),
      .HOLD_TICKS(HOLD_TICKS),
      .FADE_STEP (FADE_STEP)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .trig   (trig[i]),
      .tick   (tick),
      .pwm_cnt(pwm_q),
      .led    (outLED[i]),
      .active (outActive[i])
    );
  end

endmodule

// File: tb/tb_key_light_fader.sv
// Bench for key_light_fader: behavioural model of the hold/fade/PWM rules,
// per-cycle comparison, and hand-computed checkpoints.
module tb_key_light_fader;

  localparam int TICK_DIV = 4;
  localparam int HOLD     = 2;
  localparam int STEP     = 64;
  localparam int MAXL     = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  inSel = 8'h00;
  logic        inValid = 1'b0;
  logic [11:0] outLED, outActive;
  logic [7:0]  outLED8, outActive8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_light_fader #(.N_CH(12), .PWM_BITS(8), .TICK_DIV(TICK_DIV),
                    .HOLD_TICKS(HOLD), .FADE_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .inSel(inSel), .inValid(inValid),
    .outLED(outLED), .outActive(outActive));

  key_light_fader #(.N_CH(8), .PWM_BITS(8), .TICK_DIV(TICK_DIV),
                    .HOLD_TICKS(HOLD), .FADE_STEP(STEP)) dut8 (
    .clk(clk), .rst(rst), .inSel(inSel), .inValid(inValid),
    .outLED(outLED8), .outActive(outActive8));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  string       keys = "zsxdcvgbhnjm";
  int          m_lvl  [12];
  int          m_hold [12];
  int          m_cyc;
  logic [11:0] exp_led, exp_act;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_lvl[c]) begin m_lvl[c] = 0; m_hold[c] = 0; end
      m_cyc = 0; exp_led = '0; exp_act = '0;
    end else begin
      int hit_ch;
      bit is_tick;
      hit_ch  = -1;
      is_tick = (m_cyc % TICK_DIV) == TICK_DIV - 1;
      for (int c = 0; c < 12; c++) begin
        exp_led[c] = (m_lvl[c] == MAXL) || ((m_cyc % 256) < m_lvl[c]);
        exp_act[c] = (m_lvl[c] != 0);
        if (inValid && inSel == keys[c]) hit_ch = c;
      end
      for (int c = 0; c < 12; c++) begin
        if (c == hit_ch) begin
          m_lvl[c] = MAXL; m_hold[c] = HOLD;
        end else if (is_tick) begin
          if (m_hold[c] > 0) m_hold[c]--;
          else m_lvl[c] = (m_lvl[c] > STEP) ? m_lvl[c] - STEP : 0;
        end
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("led12", 32'(outLED), 32'(exp_led));
      check("act12", 32'(outActive), 32'(exp_act));
      check("led8", 32'(outLED8), 32'(exp_led[7:0]));
      check("act8", 32'(outActive8), 32'(exp_act[7:0]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] code);
    inSel = code; inValid = 1'b1;
    step(1);
    inValid = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    int guard = 0;
    while ((m_cyc % TICK_DIV) != p && guard < 16) begin
      step(1); guard++;
    end
    if (guard >= 16) check("phase_timeout", 1, 0);
  endtask

  initial begin
    step(2);
    check("reset_led", 32'(outLED), 0);
    check("reset_act", 32'(outActive), 0);
    rst = 1'b0;

    // z trigger at edge 0; ticks fall on edges 3,7,11,...
    wait_phase(0);
    press(8'h7A);
    step(1);
    check("z_active", 32'(outActive), 32'h001);
    check("z_level_dut", 32'(dut.g_ch[0].u_ch.level_q), 255);
    step(10);
    check("fade1_model", m_lvl[0], 191);
    check("fade1_dut", 32'(dut.g_ch[0].u_ch.level_q), 191);
    step(4);
    check("fade2_model", m_lvl[0], 127);
    press(8'h6D);
    step(1);
    check("m_active12", 32'(outActive), 32'h801);
    check("m_active8", 32'(outActive8), 32'h01);
    step(2);
    check("fade3_model", m_lvl[0], 63);
    check("fade3_dut", 32'(dut.g_ch[0].u_ch.level_q), 63);
    press(8'h7A);
    check("retrig_model", m_lvl[0], 255);
    check("retrig_dut", 32'(dut.g_ch[0].u_ch.level_q), 255);
    check("retrig_hold", 32'(dut.g_ch[0].u_ch.hold_q), 2);

    // Let everything decay, then poke with ignored inputs.
    step(80);
    check("all_off", 32'(outActive), 0);
    press(8'h41);
    for (int i = 0; i < 5; i++) begin
      inSel = 8'h60 + 8'(i * 3);
      step(1);
    end
    step(2);
    check("ignored_act", 32'(outActive), 0);
    press(8'h6D);
    step(2);
    check("m_n12", 32'(outActive), 32'h800);
    check("m_n8", 32'(outActive8), 32'h00);

    // Trigger on the same edge as a tick.
    step(60);
    wait_phase(TICK_DIV - 1);
    press(8'h7A);
    check("tick_trig_level", 32'(dut.g_ch[0].u_ch.level_q), 255);
    check("tick_trig_hold", 32'(dut.g_ch[0].u_ch.hold_q), 2);
    check("tick_trig_model", m_hold[0], 2);

    // Asynchronous reset in the middle of the fade.
    step(14);
    check("pre_rst_model", m_lvl[0], 191);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_led", 32'(outLED), 0);
    check("async_act", 32'(outActive), 0);
    check("async_act8", 32'(outActive8), 0);
    @(negedge clk);
    rst = 1'b0;
    step(3);
    check("post_rst_act", 32'(outActive), 0);
    check("post_rst_led", 32'(outLED), 0);
    step(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
